huffman_encoder: RTL and testbench

Serializes JPEG run/size symbols into Huffman code bits using the baseline luminance tables (ITU-T T.81 Annex K.3 DC, K.5 AC). It is the transmit-side counterpart of `Huffman_Decoder`. It accepts one (R, S, ac_dc_flag) symbol per handshake. It emits the code MSB-first on `next_bit` qualified by `is_new`, one bit per cycle, so its output connects directly to the decoder's bit input for loopback.

---
 rtl/huffman_pkg.sv | 30 +++
 rtl/huffman_code_rom.sv | 124 ++++++++++++
 rtl/huffman_encoder.sv | 101 ++++++++++
 tb/tb_huffman_encoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared types and constants for the JPEG baseline luminance Huffman encoder.
// Code words are carried left-aligned in a MAX_CODE_LEN-bit field.
package huffman_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MAX_CODE_LEN = 16;
  localparam int CNT_W        = $clog2(MAX_CODE_LEN);

  localparam logic [3:0] DC_MAX_CAT = 4'd11;
  localparam logic [3:0] AC_MAX_CAT = 4'd10;

  // End-of-block and zero-run-length AC symbols with their left-aligned codes
  localparam logic [3:0]  EOB_R    = 4'd0;
  localparam logic [3:0]  EOB_S    = 4'd0;
  localparam logic [15:0] EOB_CODE = 16'hA000;
  localparam logic [4:0]  EOB_LEN  = 5'd4;
  localparam logic [3:0]  ZRL_R    = 4'd15;
  localparam logic [3:0]  ZRL_S    = 4'd0;
  localparam logic [15:0] ZRL_CODE = 16'hFF20;
  localparam logic [4:0]  ZRL_LEN  = 5'd11;

  function automatic logic [15:0] left_align(input logic [15:0] raw, input logic [4:0] len);
    return raw << (5'd16 - len);
  endfunction

endpackage

// File: rtl/huffman_code_rom.sv
// Combinational (ac_dc_flag, R, S) -> left-aligned code and length lookup for the
// baseline luminance DC/AC tables; len = 0 marks a symbol outside the table.
module huffman_code_rom
  import huffman_pkg::*;
(
  input  logic        ac_dc_flag,
  input  logic [3:0]  r,
  input  logic [3:0]  s,
  output logic [15:0] code,
  output logic [4:0]  len
);

  logic [15:0] raw;

  // All 16-bit AC codes run consecutively from 0xFF82, ordered by R then S.
  // first_long_s is the smallest S of a run that falls into that block.
  function automatic logic [3:0] first_long_s(input logic [3:0] run);
    logic [3:0] v;
    case (run)
      4'd0:                                      v = 4'd9;
      4'd1:                                      v = 4'd6;
      4'd2:                                      v = 4'd5;
      4'd3:                                      v = 4'd4;
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8:              v = 4'd3;
      4'd9, 4'd10, 4'd11, 4'd12, 4'd13:          v = 4'd2;
      default:                                   v = 4'd1;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] long_base(input logic [3:0] run);
    logic [7:0] v;
    case (run)
      4'd0:    v = 8'd0;
      4'd1:    v = 8'd2;
      4'd2:    v = 8'd7;
      4'd3:    v = 8'd13;
      4'd4:    v = 8'd20;
      4'd5:    v = 8'd28;
      4'd6:    v = 8'd36;
      4'd7:    v = 8'd44;
      4'd8:    v = 8'd52;
      4'd9:    v = 8'd60;
      4'd10:   v = 8'd69;
      4'd11:   v = 8'd78;
      4'd12:   v = 8'd87;
      4'd13:   v = 8'd96;
      4'd14:   v = 8'd105;
      default: v = 8'd115;
    endcase
    return v;
  endfunction

  always_comb begin
    raw = '0;
    len = '0;
    if (ac_dc_flag) begin
      if (r == 4'd0 && s <= DC_MAX_CAT) begin
        case (s)
          4'd0:    begin raw = 16'b00;        len = 5'd2; end
          4'd1:    begin raw = 16'b010;       len = 5'd3; end
          4'd2:    begin raw = 16'b011;       len = 5'd3; end
          4'd3:    begin raw = 16'b100;       len = 5'd3; end
          4'd4:    begin raw = 16'b101;       len = 5'd3; end
          4'd5:    begin raw = 16'b110;       len = 5'd3; end
          4'd6:    begin raw = 16'b1110;      len = 5'd4; end
          4'd7:    begin raw = 16'b11110;     len = 5'd5; end
          4'd8:    begin raw = 16'b111110;    len = 5'd6; end
          4'd9:    begin raw = 16'b1111110;   len = 5'd7; end
          4'd10:   begin raw = 16'b11111110;  len = 5'd8; end
          4'd11:   begin raw = 16'b111111110; len = 5'd9; end
          default: ;
        endcase
      end
    end else if ((s >= 4'd1 && s <= AC_MAX_CAT) ||
                 ({r, s} == {EOB_R, EOB_S}) || ({r, s} == {ZRL_R, ZRL_S})) begin
      case ({r, s})
        {EOB_R, EOB_S}: begin raw = EOB_CODE >> (5'd16 - EOB_LEN); len = EOB_LEN; end
        {ZRL_R, ZRL_S}: begin raw = ZRL_CODE >> (5'd16 - ZRL_LEN); len = ZRL_LEN; end
        8'h01: begin raw = 16'b00;              len = 5'd2;  end
        8'h02: begin raw = 16'b01;              len = 5'd2;  end
        8'h03: begin raw = 16'b100;             len = 5'd3;  end
        8'h04: begin raw = 16'b1011;            len = 5'd4;  end
        8'h11: begin raw = 16'b1100;            len = 5'd4;  end
        8'h05: begin raw = 16'b11010;           len = 5'd5;  end
        8'h12: begin raw = 16'b11011;           len = 5'd5;  end
        8'h21: begin raw = 16'b11100;           len = 5'd5;  end
        8'h31: begin raw = 16'b111010;          len = 5'd6;  end
        8'h41: begin raw = 16'b111011;          len = 5'd6;  end
        8'h06: begin raw = 16'b1111000;         len = 5'd7;  end
        8'h13: begin raw = 16'b1111001;         len = 5'd7;  end
        8'h51: begin raw = 16'b1111010;         len = 5'd7;  end
        8'h61: begin raw = 16'b1111011;         len = 5'd7;  end
        8'h07: begin raw = 16'b11111000;        len = 5'd8;  end
        8'h22: begin raw = 16'b11111001;        len = 5'd8;  end
        8'h71: begin raw = 16'b11111010;        len = 5'd8;  end
        8'h14: begin raw = 16'b111110110;       len = 5'd9;  end
        8'h32: begin raw = 16'b111110111;       len = 5'd9;  end
        8'h81: begin raw = 16'b111111000;       len = 5'd9;  end
        8'h91: begin raw = 16'b111111001;       len = 5'd9;  end
        8'hA1: begin raw = 16'b111111010;       len = 5'd9;  end
        8'h08: begin raw = 16'b1111110110;      len = 5'd10; end
        8'h23: begin raw = 16'b1111110111;      len = 5'd10; end
        8'h42: begin raw = 16'b1111111000;      len = 5'd10; end
        8'hB1: begin raw = 16'b1111111001;      len = 5'd10; end
        8'hC1: begin raw = 16'b1111111010;      len = 5'd10; end
        8'h15: begin raw = 16'b11111110110;     len = 5'd11; end
        8'h52: begin raw = 16'b11111110111;     len = 5'd11; end
        8'hD1: begin raw = 16'b11111111000;     len = 5'd11; end
        8'h24: begin raw = 16'b111111110100;    len = 5'd12; end
        8'h33: begin raw = 16'b111111110101;    len = 5'd12; end
        8'h62: begin raw = 16'b111111110110;    len = 5'd12; end
        8'h72: begin raw = 16'b111111110111;    len = 5'd12; end
        8'h82: begin raw = 16'b111111111000000; len = 5'd15; end
        default: begin
          raw = 16'hFF82 + {8'h00, long_base(r)} + {12'h000, s} - {12'h000, first_long_s(r)};
          len = 5'd16;
        end
      endcase
    end
    code = left_align(raw, len);
  end

endmodule

// File: rtl/huffman_encoder.sv
// JPEG run/size symbol to serial Huffman bit stream, MSB first, one bit per cycle.
// Define HUFF_ENC_ERR_EN to add the err pulse for accepted invalid symbols.
module huffman_encoder
  import huffman_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       ac_dc_flag,
  input  logic [3:0] r_value,
  input  logic [3:0] s_value,
  output logic       next_bit,
  output logic       is_new,
  output logic       done
`ifdef HUFF_ENC_ERR_EN
  ,
  output logic       err
`endif
);

  state_t            state, state_n;
  logic [15:0]       shift_reg, shift_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              bit_n, new_n, done_n;
  logic [15:0]       rom_code;
  logic [4:0]        rom_len;
  logic              take;

  huffman_code_rom u_rom (
    .ac_dc_flag (ac_dc_flag),
    .r          (r_value),
    .s          (s_value),
    .code       (rom_code),
    .len        (rom_len)
  );

  // Handshake: a symbol transfers on a rising edge where in_valid && in_ready;
  // in_ready is a pure state/counter decode (idle, or last bit of the current code)
  // and never looks at in_valid, so the source may hold in_valid for gapless streams.
  assign in_ready = (state == IDLE) || (cnt == '0);
  assign take     = in_valid && in_ready;

  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    cnt_n   = cnt;
    bit_n   = 1'b0;
    new_n   = 1'b0;
    done_n  = 1'b0;
    if (take) begin
      if (rom_len != '0) begin
        state_n = SHIFT;
        bit_n   = rom_code[15];
        new_n   = 1'b1;
        shift_n = {rom_code[14:0], 1'b0};
        cnt_n   = CNT_W'(rom_len - 5'd1);
        done_n  = (rom_len == 5'd1);
      end else begin
        state_n = IDLE;
      end
    end else if (state == SHIFT && cnt != '0) begin
      bit_n   = shift_reg[15];
      new_n   = 1'b1;
      shift_n = {shift_reg[14:0], 1'b0};
      cnt_n   = cnt - CNT_W'(1);
      done_n  = (cnt == CNT_W'(1));
    end else begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      next_bit  <= 1'b0;
      is_new    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      cnt       <= cnt_n;
      next_bit  <= bit_n;
      is_new    <= new_n;
      done      <= done_n;
    end
  end

`ifdef HUFF_ENC_ERR_EN
  logic err_n;
  assign err_n = take && (rom_len == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_n;
  end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Scoreboard bench for huffman_encoder: canonical-table reference model built from the
// standard BITS/HUFFVAL lists, directed cases plus randomized symbol streams.
module tb_huffman_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ac_dc_flag = 1'b0;
  logic [3:0] r_value = '0;
  logic [3:0] s_value = '0;
  logic       next_bit, is_new, done;
`ifdef HUFF_ENC_ERR_EN
  logic       err;
`endif

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  logic [0:0] err_q[$];
  logic [1:0] mon_e;
  logic [15:0] cap_bits, cap_done, cap_rdy;
  int         cap_n;

  int dc_bits[16] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
  int ac_bits[16] = '{0, 2, 1, 3, 3, 2, 4, 3, 5, 5, 4, 4, 0, 0, 1, 125};
  int ac_val[162] = '{
    'h01, 'h02, 'h03, 'h00, 'h04, 'h11, 'h05, 'h12, 'h21, 'h31, 'h41, 'h06, 'h13, 'h51, 'h61, 'h07,
    'h22, 'h71, 'h14, 'h32, 'h81, 'h91, 'ha1, 'h08, 'h23, 'h42, 'hb1, 'hc1, 'h15, 'h52, 'hd1, 'hf0,
    'h24, 'h33, 'h62, 'h72, 'h82, 'h09, 'h0a, 'h16, 'h17, 'h18, 'h19, 'h1a, 'h25, 'h26, 'h27, 'h28,
    'h29, 'h2a, 'h34, 'h35, 'h36, 'h37, 'h38, 'h39, 'h3a, 'h43, 'h44, 'h45, 'h46, 'h47, 'h48, 'h49,
    'h4a, 'h53, 'h54, 'h55, 'h56, 'h57, 'h58, 'h59, 'h5a, 'h63, 'h64, 'h65, 'h66, 'h67, 'h68, 'h69,
    'h6a, 'h73, 'h74, 'h75, 'h76, 'h77, 'h78, 'h79, 'h7a, 'h83, 'h84, 'h85, 'h86, 'h87, 'h88, 'h89,
    'h8a, 'h92, 'h93, 'h94, 'h95, 'h96, 'h97, 'h98, 'h99, 'h9a, 'ha2, 'ha3, 'ha4, 'ha5, 'ha6, 'ha7,
    'ha8, 'ha9, 'haa, 'hb2, 'hb3, 'hb4, 'hb5, 'hb6, 'hb7, 'hb8, 'hb9, 'hba, 'hc2, 'hc3, 'hc4, 'hc5,
    'hc6, 'hc7, 'hc8, 'hc9, 'hca, 'hd2, 'hd3, 'hd4, 'hd5, 'hd6, 'hd7, 'hd8, 'hd9, 'hda, 'he1, 'he2,
    'he3, 'he4, 'he5, 'he6, 'he7, 'he8, 'he9, 'hea, 'hf1, 'hf2, 'hf3, 'hf4, 'hf5, 'hf6, 'hf7, 'hf8,
    'hf9, 'hfa};

  logic [15:0] dc_code[16];
  int          dc_len[16];
  logic [15:0] ac_code[256];
  int          ac_len[256];

  huffman_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ac_dc_flag (ac_dc_flag),
    .r_value    (r_value),
    .s_value    (s_value),
    .next_bit   (next_bit),
    .is_new     (is_new),
    .done       (done)
`ifdef HUFF_ENC_ERR_EN
    ,
    .err        (err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic build_tables();
    logic [15:0] c;
    int k;
    for (int i = 0; i < 16; i++) begin dc_len[i] = 0; dc_code[i] = '0; end
    for (int i = 0; i < 256; i++) begin ac_len[i] = 0; ac_code[i] = '0; end
    c = '0; k = 0;
    for (int l = 1; l <= 16; l++) begin
      for (int j = 0; j < dc_bits[l-1]; j++) begin
        dc_code[k] = c; dc_len[k] = l; c++; k++;
      end
      c = c << 1;
    end
    c = '0; k = 0;
    for (int l = 1; l <= 16; l++) begin
      for (int j = 0; j < ac_bits[l-1]; j++) begin
        ac_code[ac_val[k]] = c; ac_len[ac_val[k]] = l; c++; k++;
      end
      c = c << 1;
    end
  endtask

  task automatic expect_sym(input logic f, input logic [3:0] r, input logic [3:0] s);
    logic [15:0] c;
    int l;
    c = '0; l = 0;
    if (f) begin
      if (r == 4'd0) begin c = dc_code[s]; l = dc_len[s]; end
    end else begin
      c = ac_code[{r, s}]; l = ac_len[{r, s}];
    end
    if (l == 0) begin
`ifdef HUFF_ENC_ERR_EN
      err_q.push_back(1'b1);
`endif
    end else begin
      for (int b = l - 1; b >= 0; b--) exp_q.push_back({c[b], (b == 0)});
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (is_new) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bit: got bit %0b with nothing expected at %0t", next_bit, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("bit", {31'd0, next_bit}, {31'd0, mon_e[1]});
          check("done", {31'd0, done}, {31'd0, mon_e[0]});
        end
        cap_bits = {cap_bits[14:0], next_bit};
        cap_done = {cap_done[14:0], done};
        cap_rdy  = {cap_rdy[14:0], in_ready};
        cap_n++;
      end else begin
        check("gap_quiet", {30'd0, next_bit, done}, 32'd0);
      end
`ifdef HUFF_ENC_ERR_EN
      if (err) begin
        total++;
        if (err_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_err: got err=1 with no invalid symbol at %0t", $time);
        end else begin
          void'(err_q.pop_front());
        end
      end
`endif
    end
  end

  // ---------------- drivers ----------------
  task automatic cap_clear();
    cap_bits = '0; cap_done = '0; cap_rdy = '0; cap_n = 0;
  endtask

  task automatic send(input logic f, input logic [3:0] r, input logic [3:0] s);
    int n;
    n = 0;
    ac_dc_flag = f; r_value = r; s_value = s; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 40);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: in_ready=0 after %0d cycles, expected 1", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    expect_sym(f, r, s);
    #1;
    in_valid   = 1'b0;
    ac_dc_flag = 1'($urandom_range(0, 1));
    r_value    = 4'($urandom_range(0, 15));
    s_value    = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((exp_q.size() != 0 || is_new) && n < 100);
    if (exp_q.size() != 0 || is_new) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d bits still pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic f;
    logic [3:0] r, s;
    build_tables();
    cap_clear();

    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_is_new", {31'd0, is_new}, 32'd0);
    check("rst_next_bit", {31'd0, next_bit}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef HUFF_ENC_ERR_EN
    check("rst_err", {31'd0, err}, 32'd0);
`endif
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    cap_clear(); send(1'b1, 4'd0, 4'd2); drain();
    check("dc02_n", cap_n, 3);
    check("dc02_bits", {16'd0, cap_bits}, 32'b011);
    check("dc02_done", {16'd0, cap_done}, 32'b001);
    check("dc02_rdy", {16'd0, cap_rdy}, 32'b001);

    cap_clear(); send(1'b0, 4'd1, 4'd2); drain();
    check("ac12_n", cap_n, 5);
    check("ac12_bits", {16'd0, cap_bits}, 32'b11011);
    check("ac12_done", {16'd0, cap_done}, 32'b00001);

    cap_clear(); send(1'b1, 4'd0, 4'd0); send(1'b0, 4'd0, 4'd0); drain();
    check("b2b_n", cap_n, 6);
    check("b2b_bits", {16'd0, cap_bits}, 32'b001010);
    check("b2b_done", {16'd0, cap_done}, 32'b010001);
    check("b2b_rdy", {16'd0, cap_rdy}, 32'b010001);

    cap_clear(); send(1'b0, 4'd15, 4'd0); drain();
    check("zrl_n", cap_n, 11);
    check("zrl_bits", {16'd0, cap_bits}, 32'b11111111001);

    cap_clear(); send(1'b0, 4'd0, 4'd10); drain();
    check("ac0a_n", cap_n, 16);
    check("ac0a_bits", {16'd0, cap_bits}, 32'hFF83);
    check("ac0a_rdy", {16'd0, cap_rdy}, 32'h0001);
    check("ac0a_done", {16'd0, cap_done}, 32'h0001);

    cap_clear(); send(1'b1, 4'd3, 4'd2);
    @(negedge clk); #1;
    check("inv_is_new", {31'd0, is_new}, 32'd0);
    check("inv_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef HUFF_ENC_ERR_EN
    check("inv_err", {31'd0, err}, 32'd1);
`endif
    send(1'b0, 4'd0, 4'd11); send(1'b0, 4'd3, 4'd0); send(1'b1, 4'd0, 4'd12);
    drain();
    check("inv_no_bits", cap_n, 0);

    send(1'b0, 4'd1, 4'd2);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_is_new", {31'd0, is_new}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_next_bit", {31'd0, next_bit}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    cap_clear(); send(1'b1, 4'd0, 4'd2); drain();
    check("arst_dc02_bits", {16'd0, cap_bits}, 32'b011);
    check("arst_dc02_n", cap_n, 3);

    for (int i = 0; i < 400; i++) begin
      f = 1'($urandom_range(0, 1));
      if (f) begin
        r = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        s = 4'($urandom_range(0, 12));
      end else begin
        r = 4'($urandom_range(0, 15));
        s = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 10));
      end
      send(f, r, s);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    drain();
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_err_q_empty", err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
